// File: rtl/vga_sig_pkg.sv
// Shared definitions for the VGA frame-signature block: FSM states and the
// CRC-32/MPEG-2 constants.
package vga_sig_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_SKIP    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_e;

    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
endpackage

// File: rtl/vga_sig_crc.sv
// One CRC-32/MPEG-2 step over a DATA_W-bit word, MSB first, non-reflected.
module vga_sig_crc
    import vga_sig_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic [31:0]       crc_in,
    input  logic [DATA_W-1:0] data,
    output logic [31:0]       crc_out
);
    logic [31:0] crc_v;

    always_comb begin
        crc_v = crc_in;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (crc_v[31] ^ data[i]) begin
                crc_v = {crc_v[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                crc_v = {crc_v[30:0], 1'b0};
            end
        end
        crc_out = crc_v;
    end
endmodule

// File: rtl/vga_frame_sig.sv
// Frame signature capture: waits for a frame boundary, optionally skips
// frames, then reports CRC-32, active pixel count and active line count.
//
// Handshake: arm is a 1-cycle request honoured only in IDLE; sig_valid is a
// 1-cycle pulse with no ready (the consumer must take it that cycle), and
// sig/pix_count/line_count hold until the next pulse or reset.
module vga_frame_sig
    import vga_sig_pkg::*;
#(
    parameter int COLOR_W = 8,
    parameter int SKIP_W  = 8,
    parameter int PIX_W   = 20,
    parameter int LINE_W  = 11
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pix_en,
    input  logic                vga_blank_z,
    input  logic                end_line,
    input  logic                end_frame,
    input  logic [COLOR_W-1:0]  red,
    input  logic [COLOR_W-1:0]  green,
    input  logic [COLOR_W-1:0]  blue,
    input  logic                arm,
    input  logic                abort,
    input  logic                continuous,
    input  logic [SKIP_W-1:0]   skip_frames,
    output logic                busy,
    output logic                sig_valid,
    output logic [31:0]         sig,
    output logic [PIX_W-1:0]    pix_count,
    output logic [LINE_W-1:0]   line_count,
    output logic [1:0]          dbg_state
);
    state_e              state_q, state_d;
    logic [SKIP_W-1:0]   skip_q, skip_d;
    logic                cont_q, cont_d;
    logic [31:0]         crc_q, crc_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                lact_q, lact_d;
    logic [31:0]         sig_q, sig_d;
    logic [PIX_W-1:0]    pixc_q, pixc_d;
    logic [LINE_W-1:0]   linec_q, linec_d;
    logic                valid_q, valid_d;

    logic                boundary;
    logic                pix_act;
    logic                line_close;
    logic                lact_or;
    logic [31:0]         crc_step;
    logic [31:0]         crc_cap;
    logic [PIX_W-1:0]    pix_cap;
    logic [LINE_W-1:0]   line_cap;
    logic                lact_cap;

    vga_sig_crc #(.DATA_W(3 * COLOR_W)) u_crc (
        .crc_in  (crc_q),
        .data    ({blue, green, red}),
        .crc_out (crc_step)
    );

    // Capture-path next values; they already include the pixel and line
    // closing on the current cycle, so a boundary result is complete.
    always_comb begin
        boundary   = pix_en & end_line & end_frame;
        pix_act    = pix_en & vga_blank_z;
        lact_or    = lact_q | pix_act;
        line_close = pix_en & end_line & lact_or;
        crc_cap    = pix_act ? crc_step : crc_q;
        pix_cap    = (pix_act && pix_q != '1) ? pix_q + PIX_W'(1) : pix_q;
        line_cap   = (line_close && line_q != '1) ? line_q + LINE_W'(1) : line_q;
        lact_cap   = line_close ? 1'b0 : lact_or;
    end

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        cont_d  = cont_q;
        crc_d   = crc_q;
        pix_d   = pix_q;
        line_d  = line_q;
        lact_d  = lact_q;
        sig_d   = sig_q;
        pixc_d  = pixc_q;
        linec_d = linec_q;
        valid_d = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        skip_d  = skip_frames;
                        cont_d  = continuous;
                        state_d = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (boundary) begin
                        state_d = (skip_q != '0) ? ST_SKIP : ST_CAPTURE;
                        crc_d   = CRC_INIT;
                        pix_d   = '0;
                        line_d  = '0;
                        lact_d  = 1'b0;
                    end
                end
                ST_SKIP: begin
                    if (boundary) begin
                        skip_d = skip_q - SKIP_W'(1);
                        if (skip_q == SKIP_W'(1)) begin
                            state_d = ST_CAPTURE;
                        end
                    end
                end
                default: begin
                    if (pix_en) begin
                        crc_d  = crc_cap;
                        pix_d  = pix_cap;
                        line_d = line_cap;
                        lact_d = lact_cap;
                    end
                    if (boundary) begin
                        sig_d   = crc_cap;
                        pixc_d  = pix_cap;
                        linec_d = line_cap;
                        valid_d = 1'b1;
                        crc_d   = CRC_INIT;
                        pix_d   = '0;
                        line_d  = '0;
                        lact_d  = 1'b0;
                        state_d = cont_q ? ST_CAPTURE : ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
            cont_q  <= 1'b0;
            crc_q   <= '0;
            pix_q   <= '0;
            line_q  <= '0;
            lact_q  <= 1'b0;
            sig_q   <= '0;
            pixc_q  <= '0;
            linec_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            cont_q  <= cont_d;
            crc_q   <= crc_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
            lact_q  <= lact_d;
            sig_q   <= sig_d;
            pixc_q  <= pixc_d;
            linec_q <= linec_d;
            valid_q <= valid_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign sig_valid  = valid_q;
    assign sig        = sig_q;
    assign pix_count  = pixc_q;
    assign line_count = linec_q;
    assign dbg_state  = state_q;
endmodule
